// File: rtl/rotate_pipelined_if.sv
// rotate_pipelined_if -- handshake bundle for the pipelined barrel rotator.
//
// Groups the input-side transfer (in_data, in_amount, optional in_direction,
// in_valid, in_ready) and the output-side transfer (out_data, out_valid,
// out_ready) of rotate_pipelined.
//   master : the producer/consumer environment (drives in_*, out_ready)
//   slave  : the rotator itself (drives in_ready, out_data, out_valid)
//
// Optional feature macro: ROTATE_PIPELINED_DIRECTION_EN adds in_direction
// (0 = rotate left, 1 = rotate right).
interface rotate_pipelined_if #(
  parameter int WIDTH = 8
);
  localparam int AMOUNT_WIDTH = $clog2(WIDTH);

  logic [WIDTH-1:0]        in_data;
  logic [AMOUNT_WIDTH-1:0] in_amount;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
  logic                    in_direction;
`endif
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;

`ifdef ROTATE_PIPELINED_DIRECTION_EN
  modport master (
    output in_data, in_amount, in_direction, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_amount, in_direction, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
`else
  modport master (
    output in_data, in_amount, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_amount, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
`endif
endinterface

// File: rtl/rotate_pipelined.sv
// rotate_pipelined -- valid/ready pipelined barrel rotator.
//
// Rotates in_data by (in_amount mod WIDTH) positions using AMOUNT_WIDTH
// registered stages; stage k rotates by (2^k mod WIDTH) when bit k of the
// carried amount is set. Latency is AMOUNT_WIDTH cycles, throughput one
// transfer per cycle, and stalls collapse bubbles stage by stage.
//
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset; empties the pipeline
//   bus    : rotate_pipelined_if.slave (in_data, in_amount, [in_direction],
//            in_valid, in_ready, out_data, out_valid, out_ready)
//
// Optional feature macro: ROTATE_PIPELINED_DIRECTION_EN
//   defined   : in_direction selects left (0) / right (1), latched per transfer
//   undefined : always rotate left, no direction registers
module rotate_pipelined #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  rotate_pipelined_if.slave    bus
);
  localparam int AMOUNT_WIDTH = $clog2(WIDTH);
  localparam int STAGES       = AMOUNT_WIDTH;

  // Stage registers
  logic [WIDTH-1:0]        data_reg   [STAGES];
  logic [AMOUNT_WIDTH-1:0] amount_reg [STAGES];
  logic [STAGES-1:0]       valid_reg;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
  logic [STAGES-1:0]       dir_reg;
  logic [STAGES-1:0]       src_dir;
`endif

  // What each stage would capture if it loads this cycle
  logic [WIDTH-1:0]        src_data   [STAGES];
  logic [AMOUNT_WIDTH-1:0] src_amount [STAGES];
  logic [STAGES-1:0]       src_valid;
  logic [WIDTH-1:0]        data_next  [STAGES];

  // load[k]: stage k captures its predecessor this edge.
  // load[STAGES] is the output handshake acceptance.
  logic [STAGES:0]         load;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // 2^gi < WIDTH for every stage, so the shift is always 1..WIDTH-1
      localparam int SHIFT = (2 ** gi) % WIDTH;
      logic [WIDTH-1:0] rot_left;

      if (gi == 0) begin : g_first
        assign src_data[gi]   = bus.in_data;
        assign src_amount[gi] = bus.in_amount;
        assign src_valid[gi]  = bus.in_valid;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
        assign src_dir[gi]    = bus.in_direction;
`endif
      end else begin : g_rest
        assign src_data[gi]   = data_reg[gi-1];
        assign src_amount[gi] = amount_reg[gi-1];
        assign src_valid[gi]  = valid_reg[gi-1];
`ifdef ROTATE_PIPELINED_DIRECTION_EN
        assign src_dir[gi]    = dir_reg[gi-1];
`endif
      end

      assign rot_left = (src_data[gi] << SHIFT) | (src_data[gi] >> (WIDTH - SHIFT));

`ifdef ROTATE_PIPELINED_DIRECTION_EN
      logic [WIDTH-1:0] rot_right;
      assign rot_right = (src_data[gi] >> SHIFT) | (src_data[gi] << (WIDTH - SHIFT));
      assign data_next[gi] = !src_amount[gi][gi] ? src_data[gi] :
                             (src_dir[gi] ? rot_right : rot_left);
`else
      assign data_next[gi] = src_amount[gi][gi] ? rot_left : src_data[gi];
`endif
    end
  endgenerate

  // Bubble-collapsing load chain, evaluated from the output backwards so
  // in_ready sees out_ready combinationally through every full stage.
  always_comb begin
    load = '0;
    load[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !valid_reg[k] || load[k+1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_reg[k]   <= '0;
        amount_reg[k] <= '0;
      end
`ifdef ROTATE_PIPELINED_DIRECTION_EN
      dir_reg <= '0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_reg[k] <= src_valid[k];
          // Payload only moves with a valid item, so an emptied stage keeps
          // its last contents instead of picking up idle-bus values.
          if (src_valid[k]) begin
            data_reg[k]   <= data_next[k];
            amount_reg[k] <= src_amount[k];
`ifdef ROTATE_PIPELINED_DIRECTION_EN
            dir_reg[k]    <= src_dir[k];
`endif
          end
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_reg[STAGES-1];
  assign bus.out_data  = data_reg[STAGES-1];

  // The last stage's control fields have no consumer; they are kept so that
  // every stage has the same shape.
  logic unused_tail;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
  assign unused_tail = ^{amount_reg[STAGES-1], dir_reg[STAGES-1]};
`else
  assign unused_tail = ^amount_reg[STAGES-1];
`endif

endmodule

// File: tb/tb_rotate_pipelined.sv
module tb_rotate_pipelined;
  logic clock;
  logic resetn;
  int   checks_total;
  int   checks_passed;

  rotate_pipelined_if #(.WIDTH(8)) bus8 ();
  rotate_pipelined_if #(.WIDTH(6)) bus6 ();

  rotate_pipelined #(.WIDTH(8)) dut8 (.clock(clock), .resetn(resetn), .bus(bus8));
  rotate_pipelined #(.WIDTH(6)) dut6 (.clock(clock), .resetn(resetn), .bus(bus6));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit-by-bit reference rotation for the 8-bit instance
  function automatic logic [7:0] ref_rot8(input logic [7:0] x, input int amt, input logic right);
    logic [7:0] r;
    int s;
    s = amt % 8;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (right) r[i] = x[(i + s) % 8];
      else       r[(i + s) % 8] = x[i];
    end
    return r;
  endfunction

  // Drive one transfer into the idle 8-bit instance with out_ready high and
  // report the result and the cycle count until out_valid (-1 = never).
  task automatic run_single(input logic [7:0] d, input logic [2:0] a,
                            output logic [7:0] res, output int lat);
    res = 'x;
    lat = -1;
    @(negedge clock);
    bus8.in_valid  = 1'b1;
    bus8.in_data   = d;
    bus8.in_amount = a;
    bus8.out_ready = 1'b1;
    @(negedge clock);
    bus8.in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (bus8.out_valid) begin
        res = bus8.out_data;
        lat = c;
        break;
      end
      @(negedge clock);
    end
    $display("xfer w8 in=%h amt=%0d -> out=%h latency=%0d", d, a, res, lat);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks_total++;
    if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid_during: got %b expected 0", bus8.out_valid);
    else checks_passed++;
    checks_total++;
    if (bus8.out_data !== 8'h00) $display("FAIL reset_out_data_during: got %h expected 00", bus8.out_data);
    else checks_passed++;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    #1;
    checks_total++;
    if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid_after: got %b expected 0", bus8.out_valid);
    else checks_passed++;
    checks_total++;
    if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b expected 1", bus8.in_ready);
    else checks_passed++;
    checks_total++;
    if (bus8.out_data !== 8'h00) $display("FAIL reset_out_data_after: got %h expected 00", bus8.out_data);
    else checks_passed++;
    checks_total++;
    if (bus6.out_valid !== 1'b0) $display("FAIL reset_w6_out_valid: got %b expected 0", bus6.out_valid);
    else checks_passed++;
  endtask

  task automatic test_rotate_left();
    logic [7:0] din [4];
    logic [2:0] amt [4];
    logic [7:0] exp [4];
    logic [7:0] res;
    int lat;
    din = '{8'h81, 8'hA5, 8'h81, 8'h3C};
    amt = '{3'd1,  3'd0,  3'd7,  3'd4};
    exp = '{8'h03, 8'hA5, 8'hC0, 8'hC3};
`ifdef ROTATE_PIPELINED_DIRECTION_EN
    bus8.in_direction = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      run_single(din[i], amt[i], res, lat);
      checks_total++;
      if (res !== exp[i]) $display("FAIL left_data[%0d]: got %h expected %h", i, res, exp[i]);
      else checks_passed++;
      checks_total++;
      if (lat != 3) $display("FAIL left_latency[%0d]: got %0d expected 3", i, lat);
      else checks_passed++;
    end
  endtask

`ifdef ROTATE_PIPELINED_DIRECTION_EN
  task automatic test_direction();
    logic [7:0] din [4];
    logic [2:0] amt [4];
    logic       dir [4];
    logic [7:0] exp [4];
    logic [7:0] res;
    int lat;
    din = '{8'h01, 8'h01, 8'h81, 8'h01};
    amt = '{3'd3,  3'd0,  3'd1,  3'd3};
    dir = '{1'b1,  1'b1,  1'b1,  1'b0};
    exp = '{8'h20, 8'h01, 8'hC0, 8'h08};
    for (int i = 0; i < 4; i++) begin
      bus8.in_direction = dir[i];
      run_single(din[i], amt[i], res, lat);
      checks_total++;
      if (res !== exp[i]) $display("FAIL dir_data[%0d]: got %h expected %h", i, res, exp[i]);
      else checks_passed++;
    end
    bus8.in_direction = 1'b0;
  endtask
`endif

  task automatic test_width6();
    logic [5:0] din [3];
    logic [2:0] amt [3];
    logic [5:0] exp [3];
    logic [5:0] res;
    int lat;
    din = '{6'b000001, 6'b100000, 6'b101101};
    amt = '{3'd7,      3'd5,      3'd6};
    exp = '{6'b000010, 6'b010000, 6'b101101};
    for (int i = 0; i < 3; i++) begin
      res = 'x;
      lat = -1;
      @(negedge clock);
      bus6.in_valid  = 1'b1;
      bus6.in_data   = din[i];
      bus6.in_amount = amt[i];
      bus6.out_ready = 1'b1;
      @(negedge clock);
      bus6.in_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        #1;
        if (bus6.out_valid) begin
          res = bus6.out_data;
          lat = c;
          break;
        end
        @(negedge clock);
      end
      $display("xfer w6 in=%b amt=%0d -> out=%b latency=%0d", din[i], amt[i], res, lat);
      checks_total++;
      if (res !== exp[i]) $display("FAIL w6_data[%0d]: got %b expected %b", i, res, exp[i]);
      else checks_passed++;
      checks_total++;
      if (lat != 3) $display("FAIL w6_latency[%0d]: got %0d expected 3", i, lat);
      else checks_passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] in_vals  [4];
    logic [7:0] exp_vals [4];
    int sent;
    int got;
    in_vals  = '{8'h01, 8'h02, 8'h04, 8'h08};
    exp_vals = '{8'h02, 8'h04, 8'h08, 8'h10};
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clock);
      bus8.out_ready = (cyc >= 5);
      bus8.in_valid  = (sent < 4);
      bus8.in_data   = (sent < 4) ? in_vals[sent] : 8'h00;
      bus8.in_amount = 3'd1;
      #1;
      if (cyc == 2) begin
        checks_total++;
        if (bus8.in_ready !== 1'b1) $display("FAIL b2b_in_ready_c2: got %b expected 1", bus8.in_ready);
        else checks_passed++;
      end
      if (cyc == 3 || cyc == 4) begin
        checks_total++;
        if (bus8.in_ready !== 1'b0) $display("FAIL b2b_in_ready_full_c%0d: got %b expected 0", cyc, bus8.in_ready);
        else checks_passed++;
        checks_total++;
        if (bus8.out_valid !== 1'b1 || bus8.out_data !== 8'h02)
          $display("FAIL b2b_hold_c%0d: got valid=%b data=%h expected valid=1 data=02", cyc, bus8.out_valid, bus8.out_data);
        else checks_passed++;
      end
      if (bus8.in_valid && bus8.in_ready) sent++;
      if (bus8.out_valid && bus8.out_ready) begin
        $display("xfer b2b out[%0d]=%h", got, bus8.out_data);
        checks_total++;
        if (bus8.out_data !== exp_vals[got]) $display("FAIL b2b_order[%0d]: got %h expected %h", got, bus8.out_data, exp_vals[got]);
        else checks_passed++;
        got++;
      end
    end
    @(negedge clock);
    bus8.in_valid = 1'b0;
    checks_total++;
    if (got != 4) $display("FAIL b2b_count: got %0d results expected 4", got);
    else checks_passed++;
  endtask

  task automatic test_reset_midflight();
    logic [7:0] res;
    int lat;
    int stray;
    @(negedge clock);
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = 8'h11;
    bus8.in_amount = 3'd1;
    @(negedge clock);
    bus8.in_data   = 8'h22;
    @(negedge clock);
    bus8.in_valid  = 1'b0;
    @(negedge clock);
    #1;
    checks_total++;
    if (bus8.out_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b expected 1", bus8.out_valid);
    else checks_passed++;
    resetn = 1'b0;
    #1;
    checks_total++;
    if (bus8.out_valid !== 1'b0) $display("FAIL midrst_immediate_valid: got %b expected 0", bus8.out_valid);
    else checks_passed++;
    checks_total++;
    if (bus8.out_data !== 8'h00) $display("FAIL midrst_out_data: got %h expected 00", bus8.out_data);
    else checks_passed++;
    @(negedge clock);
    resetn = 1'b1;
    bus8.out_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      #1;
      if (bus8.out_valid) stray++;
    end
    checks_total++;
    if (stray != 0) $display("FAIL midrst_stale: got %0d stale outputs expected 0", stray);
    else checks_passed++;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
    bus8.in_direction = 1'b0;
`endif
    run_single(8'hF0, 3'd4, res, lat);
    checks_total++;
    if (res !== 8'h0F) $display("FAIL midrst_next: got %h expected 0F", res);
    else checks_passed++;
    checks_total++;
    if (lat != 3) $display("FAIL midrst_next_latency: got %0d expected 3", lat);
    else checks_passed++;
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    logic [7:0] prev_data;
    logic       prev_stall;
    logic       right;
    int sent;
    int got;
    int cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (got < 10000 && cyc < 60000) begin
      @(negedge clock);
      bus8.in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      bus8.in_data   = 8'($urandom);
      bus8.in_amount = 3'($urandom_range(7));
      right = 1'b0;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
      right = 1'($urandom_range(1));
      bus8.in_direction = right;
`endif
      bus8.out_ready = ($urandom_range(3) != 0);
      #1;
      if (prev_stall) begin
        checks_total++;
        if (bus8.out_valid !== 1'b1 || bus8.out_data !== prev_data)
          $display("FAIL rand_stall_hold: got valid=%b data=%h expected valid=1 data=%h", bus8.out_valid, bus8.out_data, prev_data);
        else checks_passed++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(ref_rot8(bus8.in_data, int'(bus8.in_amount), right));
        sent++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        checks_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra_output: got %h expected no output", bus8.out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus8.out_data !== exp_v) $display("FAIL rand_data[%0d]: got %h expected %h", got, bus8.out_data, exp_v);
          else checks_passed++;
        end
        got++;
        if (got % 2000 == 0) $display("xfer random progress %0d results", got);
      end
      prev_stall = bus8.out_valid && !bus8.out_ready;
      prev_data  = bus8.out_data;
      cyc++;
    end
    @(negedge clock);
    bus8.in_valid = 1'b0;
    checks_total++;
    if (got != 10000 || exp_q.size() != 0)
      $display("FAIL rand_count: got %0d results (%0d pending) expected 10000 (0 pending)", got, exp_q.size());
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    resetn = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_amount = '0; bus8.out_ready = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_data = '0; bus6.in_amount = '0; bus6.out_ready = 1'b0;
`ifdef ROTATE_PIPELINED_DIRECTION_EN
    bus8.in_direction = 1'b0;
    bus6.in_direction = 1'b0;
`endif
    test_reset();
    test_rotate_left();
`ifdef ROTATE_PIPELINED_DIRECTION_EN
    test_direction();
`endif
    test_width6();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/rotate_pipelined.md
ROTATE_PIPELINED -- requirements
Module: rotate_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data vector width in bits (>=2).
REQ-002 SHALL have localparam AMOUNT_WIDTH = clog2(WIDTH), meaning rotation amount width and number of pipeline stages.
REQ-003 SHALL have port clock  input  1  system clock, rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  WIDTH  vector to rotate.
REQ-006 SHALL have port in_amount  input  AMOUNT_WIDTH  rotation amount in bit positions.
REQ-007 SHALL have port in_direction  input  1  0 = left, 1 = right (present only with ROTATE_PIPELINED_DIRECTION_EN).
REQ-008 SHALL have port in_valid  input  1  input transfer request.
REQ-009 SHALL have port in_ready  output  1  block can accept input this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  rotated vector.
REQ-011 SHALL have port out_valid  output  1  out_data holds a result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.

Function
REQ-013 SHALL transfer an input when in_valid and in_ready are both high on a rising clock edge; the same rule applies at the output with out_valid and out_ready.
REQ-014 SHALL implement AMOUNT_WIDTH registered stages; stage k (k = 0 first) rotates by (2^k mod WIDTH) positions when bit k of the carried amount is 1, otherwise passes data unchanged.
REQ-015 SHALL produce the result of rotating in_data by (in_amount mod WIDTH), including non-power-of-two WIDTH with in_amount >= WIDTH.
REQ-016 SHALL carry data, remaining amount bits and direction alongside a per-stage valid bit.
REQ-017 SHALL have a latency of exactly AMOUNT_WIDTH cycles from input transfer to out_valid with no backpressure.
REQ-018 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-019 SHALL make each stage load when it is empty or its successor loads in the same cycle (bubble collapsing); the last stage's successor is the output handshake.
REQ-020 SHALL drive in_ready as first-stage-empty OR first-stage-advancing, combinationally dependent on out_ready through the chain.
REQ-021 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-022 SHALL preserve transfer order; no data loss or duplication under any out_ready pattern.
REQ-023 SHALL pass in_data unchanged when the amount is 0 (mod WIDTH).

Reset
REQ-024 SHALL clear all stage valid bits asynchronously when resetn is low; out_valid = 0, in_ready = 1 after reset release.
REQ-025 SHALL reset stage data, amount and direction registers to 0; out_data = 0 during and after reset.
REQ-026 SHALL discard all in-flight transfers on reset mid-operation; no stale result appears afterwards.

Configuration
REQ-027 SHALL, with macro ROTATE_PIPELINED_DIRECTION_EN defined, include in_direction and rotate right when it is 1 at input transfer, the direction being latched per transfer.
REQ-028 SHALL, without ROTATE_PIPELINED_DIRECTION_EN, omit in_direction and always rotate left, with no direction registers.

Verification
REQ-029 SHALL cover WIDTH=8: in_data=0x81, amount=1, left -> out_data=0x03 exactly 3 cycles later.
REQ-030 SHALL cover WIDTH=8, DIRECTION_EN: in_data=0x01, amount=3, right -> 0x20; amount=0 -> 0x01.
REQ-031 SHALL cover WIDTH=6: in_data=6'b000001, amount=7 -> 6'b000010 (7 mod 6 = 1).
REQ-032 SHALL cover back-to-back inputs 0x01,0x02,0x04,0x08 with amount=1 and out_ready held low 5 cycles -> in_ready low once 3 stages full, out_data held at 0x02, then 0x02,0x04,0x08,0x10 in order.
REQ-033 SHALL cover resetn pulsed low with 2 transfers in flight -> out_valid 0 immediately, no output after release, next input 0xF0 amount=4 -> 0x0F.
REQ-034 SHALL cover random in_valid/out_ready over 10000 transfers against a reference model -> all results match, in order.
